// File: rtl/brick_renderer.sv
// Breakout pixel renderer: decodes border, ball, paddle and brick field from VGA
// counters, with a vsync-counted win/lose flash. Every output is 2 pxl_clk cycles behind hcount/vcount.
module brick_renderer #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int BORDER         = 16,
  parameter int NUM_ROWS       = 3,
  parameter int BLOCKS_PER_ROW = 8,
  parameter int BLOCK_W_LOG2   = 6,
  parameter int BLOCK_H        = 16,
  parameter int ROW_PITCH      = 24,
  parameter int BLK_X0         = 64,
  parameter int BLK_Y0         = 48,
  parameter int PADDLE_Y       = 440,
  parameter int PADDLE_H       = 8,
  parameter int PADDLE_HALF    = 32,
  parameter int BALL_R         = 3,
  parameter int RGB_W          = 3,
  parameter int FLASH_FRAMES   = 8
) (
  input  logic                               pxl_clk,
  input  logic                               reset,
  input  logic [9:0]                         hcount,
  input  logic [9:0]                         vcount,
  input  logic                               vsync,
  input  logic [9:0]                         ball_x,
  input  logic [9:0]                         ball_y,
  input  logic [9:0]                         paddle_x,
  input  logic [NUM_ROWS*BLOCKS_PER_ROW-1:0] block_status,
  input  logic                               win,
  input  logic                               lose,
  output logic [RGB_W-1:0]                   rgb,
  output logic                               drawing_player,
  output logic [NUM_ROWS-1:0]                drawing_block,
  output logic [3:0]                         block_col,
  output logic [1:0]                         flash_state
);

  localparam int COL_W = $clog2(BLOCKS_PER_ROW);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [10:0] H_ACT_L      = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_L      = 11'(V_ACTIVE);
  localparam logic [10:0] BORDER_L     = 11'(BORDER);
  localparam logic [10:0] RBORDER_L    = 11'(H_ACTIVE - BORDER);
  localparam logic [10:0] BALL_R_L     = 11'(BALL_R);
  localparam logic [10:0] PAD_Y_L      = 11'(PADDLE_Y);
  localparam logic [10:0] PAD_Y_END_L  = 11'(PADDLE_Y + PADDLE_H);
  localparam logic [10:0] PAD_HALF_L   = 11'(PADDLE_HALF);
  localparam logic [10:0] FIELD_X0_L   = 11'(BLK_X0);
  localparam logic [10:0] FIELD_X1_L   = 11'(BLK_X0 + (BLOCKS_PER_ROW << BLOCK_W_LOG2));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_FLASH_ON  = 2'd1,
    ST_FLASH_OFF = 2'd2
  } flash_state_e;

  flash_state_e     state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             vsync_prev_q;
  logic             vsync_rise;

  // ---------------- stage 1: region decode ----------------
  logic [10:0] h, v, bx, by, px;
  logic [10:0] dx, dy, pad_left, pad_right;
  logic        vis_d, border_d, ball_d, paddle_d, in_field_x;
  logic [3:0]  col_d;
  logic [COL_W-1:0] col_sel;
  logic [NUM_ROWS-1:0] row_hit, row_alive;
  logic [ROW_W-1:0]    row_idx_d;

  assign h  = {1'b0, hcount};
  assign v  = {1'b0, vcount};
  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign px = {1'b0, paddle_x};

  assign vis_d    = (h < H_ACT_L) && (v < V_ACT_L);
  assign border_d = (h < BORDER_L) || (h >= RBORDER_L) || (v < BORDER_L);

  assign dx     = (h >= bx) ? (h - bx) : (bx - h);
  assign dy     = (v >= by) ? (v - by) : (by - v);
  assign ball_d = (dx < BALL_R_L) && (dy < BALL_R_L);

  // Left paddle edge saturates at 0 so a paddle hugging the wall does not wrap.
  assign pad_left  = (px < PAD_HALF_L) ? 11'd0 : (px - PAD_HALF_L);
  assign pad_right = px + PAD_HALF_L;
  assign paddle_d  = (v >= PAD_Y_L) && (v < PAD_Y_END_L) &&
                     (h >= pad_left) && (h < pad_right);

  assign in_field_x = (h >= FIELD_X0_L) && (h < FIELD_X1_L);
  assign col_d      = in_field_x ? 4'((h - FIELD_X0_L) >> BLOCK_W_LOG2) : 4'd0;
  assign col_sel    = col_d[COL_W-1:0];

  for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
    localparam logic [10:0] ROW_TOP = 11'(BLK_Y0 + gi * ROW_PITCH);
    localparam logic [10:0] ROW_END = 11'(BLK_Y0 + gi * ROW_PITCH + BLOCK_H);
    logic [BLOCKS_PER_ROW-1:0] row_bits;
    assign row_bits      = block_status[gi*BLOCKS_PER_ROW +: BLOCKS_PER_ROW];
    assign row_hit[gi]   = in_field_x && (v >= ROW_TOP) && (v < ROW_END);
    assign row_alive[gi] = row_hit[gi] && row_bits[col_sel];
  end

  always_comb begin
    row_idx_d = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_hit[r]) row_idx_d = ROW_W'(r);
    end
  end

  logic                vis_q, border_q, ball_q, paddle_q, alive_q;
  logic [NUM_ROWS-1:0] row_hit_q;
  logic [ROW_W-1:0]    row_idx_q;
  logic [3:0]          col_q;

  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      vis_q     <= 1'b0;
      border_q  <= 1'b0;
      ball_q    <= 1'b0;
      paddle_q  <= 1'b0;
      alive_q   <= 1'b0;
      row_hit_q <= '0;
      row_idx_q <= '0;
      col_q     <= '0;
    end else begin
      vis_q     <= vis_d;
      border_q  <= border_d;
      ball_q    <= ball_d;
      paddle_q  <= paddle_d;
      alive_q   <= |row_alive;
      row_hit_q <= row_hit;
      row_idx_q <= row_idx_d;
      col_q     <= col_d;
    end
  end

  // ---------------- stage 2: colour and flags ----------------
  logic [RGB_W-1:0]    brick_sum, brick_rgb, rgb_d;
  logic                player_d;
  logic [NUM_ROWS-1:0] block_d;
  logic [3:0]          bcol_d;

  assign brick_sum = RGB_W'(row_idx_q) + RGB_W'(col_q);
  assign brick_rgb = (brick_sum == '0) ? RGB_W'(3) : brick_sum;

  always_comb begin
    rgb_d = '0;
    if (!vis_q) begin
      rgb_d = '0;
    end else if (state_q == ST_FLASH_ON) begin
      if (win)       rgb_d = '1;
      else if (lose) rgb_d = RGB_W'(1);
    end else if (state_q == ST_FLASH_OFF) begin
      rgb_d = '0;
    end else if (border_q) begin
      rgb_d = RGB_W'(2);
    end else if (ball_q || paddle_q) begin
      rgb_d = '1;
    end else if (alive_q) begin
      rgb_d = brick_rgb;
    end
  end

  assign player_d = vis_q && paddle_q && !border_q;
  assign block_d  = vis_q ? row_hit_q : '0;
  assign bcol_d   = (|block_d) ? col_q : 4'd0;

  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      rgb            <= '0;
      drawing_player <= 1'b0;
      drawing_block  <= '0;
      block_col      <= '0;
    end else begin
      rgb            <= rgb_d;
      drawing_player <= player_d;
      drawing_block  <= block_d;
      block_col      <= bcol_d;
    end
  end

  // ---------------- flash FSM ----------------
  assign vsync_rise = vsync && !vsync_prev_q;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (!win && !lose) begin
      state_d     = ST_PLAY;
      frame_cnt_d = '0;
    end else if (state_q == ST_PLAY) begin
      // Entry cycle ignores any coincident vsync edge.
      state_d     = ST_FLASH_ON;
      frame_cnt_d = '0;
    end else if (vsync_rise) begin
      if (frame_cnt_q == CNT_LAST) begin
        state_d     = (state_q == ST_FLASH_ON) ? ST_FLASH_OFF : ST_FLASH_ON;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pxl_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_PLAY;
      frame_cnt_q  <= '0;
      vsync_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      vsync_prev_q <= vsync;
    end
  end

  assign flash_state = state_q;

endmodule

// File: tb/tb_brick_renderer.sv
// Directed bench for brick_renderer with default parameters; expected values hand-computed.
module tb_brick_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hcount, vcount;
  logic        vsync;
  logic [9:0]  ball_x, ball_y, paddle_x;
  logic [23:0] block_status;
  logic        win, lose;
  logic [2:0]  rgb;
  logic        drawing_player;
  logic [2:0]  drawing_block;
  logic [3:0]  block_col;
  logic [1:0]  flash_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  brick_renderer dut (
    .pxl_clk        (clk),
    .reset          (reset),
    .hcount         (hcount),
    .vcount         (vcount),
    .vsync          (vsync),
    .ball_x         (ball_x),
    .ball_y         (ball_y),
    .paddle_x       (paddle_x),
    .block_status   (block_status),
    .win            (win),
    .lose           (lose),
    .rgb            (rgb),
    .drawing_player (drawing_player),
    .drawing_block  (drawing_block),
    .block_col      (block_col),
    .flash_state    (flash_state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic show(input int h, input int v);
    hcount = 10'(h);
    vcount = 10'(v);
    tick(2);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    tick(2);
    vsync = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    win = 1'b1;
    show(300, 444);
    tick(1);
    n_cmp++;
    if (flash_state !== 2'd1) begin
      n_err++; $display("FAIL pre_reset_flash: got %0d want 1", flash_state);
    end
    n_cmp++;
    if (drawing_player !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_player: got %0b want 1", drawing_player);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rgb !== 3'd0 || flash_state !== 2'd0 || drawing_player !== 1'b0 || drawing_block !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got rgb=%0d fs=%0d pl=%0b blk=%b want 0/0/0/000",
               rgb, flash_state, drawing_player, drawing_block);
    end
    @(negedge clk);
    win = 1'b0;
    hcount = 10'd0;
    vcount = 10'd0;
    tick(1);
    reset = 1'b0;
    tick(1);
    n_cmp++;
    if (rgb !== 3'd0) begin
      n_err++; $display("FAIL reset_latency1: got rgb=%0d want 0", rgb);
    end
    tick(1);
    n_cmp++;
    if (rgb !== 3'd2) begin
      n_err++; $display("FAIL reset_border: got rgb=%0d want 2", rgb);
    end
    $display("reset: done");
  endtask

  task automatic test_brick();
    block_status = '0;
    show(300, 300);
    block_status = 24'h000200;
    hcount = 10'd133;
    vcount = 10'd75;
    tick(1);
    n_cmp++;
    if (drawing_block !== 3'b000 || rgb !== 3'd0) begin
      n_err++; $display("FAIL brick_latency1: got blk=%b rgb=%0d want 000/0", drawing_block, rgb);
    end
    tick(1);
    n_cmp++;
    if (drawing_block !== 3'b010 || block_col !== 4'd1 || rgb !== 3'd2) begin
      n_err++; $display("FAIL brick_alive: got blk=%b col=%0d rgb=%0d want 010/1/2",
                        drawing_block, block_col, rgb);
    end
    block_status = '0;
    show(133, 75);
    n_cmp++;
    if (drawing_block !== 3'b010 || rgb !== 3'd0) begin
      n_err++; $display("FAIL brick_dead: got blk=%b rgb=%0d want 010/0", drawing_block, rgb);
    end
    $display("brick: done");
  endtask

  task automatic test_colour_sub();
    block_status = 24'h480001;  // bits 0, 19, 22
    show(70, 50);
    n_cmp++;
    if (rgb !== 3'd3 || drawing_block !== 3'b001 || block_col !== 4'd0) begin
      n_err++; $display("FAIL sub_r0c0: got rgb=%0d blk=%b col=%0d want 3/001/0", rgb, drawing_block, block_col);
    end
    show(453, 98);
    n_cmp++;
    if (rgb !== 3'd3 || drawing_block !== 3'b100 || block_col !== 4'd6) begin
      n_err++; $display("FAIL sub_r2c6: got rgb=%0d blk=%b col=%0d want 3/100/6", rgb, drawing_block, block_col);
    end
    show(261, 98);
    n_cmp++;
    if (rgb !== 3'd5 || block_col !== 4'd3) begin
      n_err++; $display("FAIL colour_r2c3: got rgb=%0d col=%0d want 5/3", rgb, block_col);
    end
    show(300, 300);
    n_cmp++;
    if (drawing_block !== 3'b000 || block_col !== 4'd0) begin
      n_err++; $display("FAIL outside_field: got blk=%b col=%0d want 000/0", drawing_block, block_col);
    end
    block_status = '0;
    $display("colour_sub: done");
  endtask

  task automatic test_ball_paddle();
    ball_x = 10'd300; ball_y = 10'd444; paddle_x = 10'd300;
    show(300, 444);
    n_cmp++;
    if (rgb !== 3'd7 || drawing_player !== 1'b1) begin
      n_err++; $display("FAIL ball_on_paddle: got rgb=%0d pl=%0b want 7/1", rgb, drawing_player);
    end
    show(331, 441);
    n_cmp++;
    if (rgb !== 3'd7 || drawing_player !== 1'b1) begin
      n_err++; $display("FAIL paddle_right_in: got rgb=%0d pl=%0b want 7/1", rgb, drawing_player);
    end
    show(332, 441);
    n_cmp++;
    if (rgb !== 3'd0 || drawing_player !== 1'b0) begin
      n_err++; $display("FAIL paddle_right_out: got rgb=%0d pl=%0b want 0/0", rgb, drawing_player);
    end
    ball_x = 10'd300; ball_y = 10'd200;
    show(302, 202);
    n_cmp++;
    if (rgb !== 3'd7 || drawing_player !== 1'b0) begin
      n_err++; $display("FAIL ball_edge_in: got rgb=%0d pl=%0b want 7/0", rgb, drawing_player);
    end
    show(303, 200);
    n_cmp++;
    if (rgb !== 3'd0) begin
      n_err++; $display("FAIL ball_edge_out: got rgb=%0d want 0", rgb);
    end
    paddle_x = 10'd10;
    show(0, 444);
    n_cmp++;
    if (rgb !== 3'd2 || drawing_player !== 1'b0) begin
      n_err++; $display("FAIL paddle_clamp_border: got rgb=%0d pl=%0b want 2/0", rgb, drawing_player);
    end
    show(20, 444);
    n_cmp++;
    if (rgb !== 3'd7 || drawing_player !== 1'b1) begin
      n_err++; $display("FAIL paddle_clamp_in: got rgb=%0d pl=%0b want 7/1", rgb, drawing_player);
    end
    show(42, 444);
    n_cmp++;
    if (drawing_player !== 1'b0) begin
      n_err++; $display("FAIL paddle_clamp_right: got pl=%0b want 0", drawing_player);
    end
    show(20, 448);
    n_cmp++;
    if (drawing_player !== 1'b0 || rgb !== 3'd0) begin
      n_err++; $display("FAIL paddle_bottom: got rgb=%0d pl=%0b want 0/0", rgb, drawing_player);
    end
    paddle_x = 10'd320;
    $display("ball_paddle: done");
  endtask

  task automatic test_visible_border();
    show(640, 100);
    n_cmp++;
    if (rgb !== 3'd0) begin
      n_err++; $display("FAIL h_offscreen: got rgb=%0d want 0", rgb);
    end
    show(630, 100);
    n_cmp++;
    if (rgb !== 3'd2) begin
      n_err++; $display("FAIL right_border: got rgb=%0d want 2", rgb);
    end
    show(15, 300);
    n_cmp++;
    if (rgb !== 3'd2) begin
      n_err++; $display("FAIL left_border: got rgb=%0d want 2", rgb);
    end
    show(16, 300);
    n_cmp++;
    if (rgb !== 3'd0) begin
      n_err++; $display("FAIL left_border_end: got rgb=%0d want 0", rgb);
    end
    show(300, 15);
    n_cmp++;
    if (rgb !== 3'd2) begin
      n_err++; $display("FAIL top_border: got rgb=%0d want 2", rgb);
    end
    show(300, 479);
    n_cmp++;
    if (rgb !== 3'd0) begin
      n_err++; $display("FAIL bottom_open: got rgb=%0d want 0", rgb);
    end
    $display("visible_border: done");
  endtask

  task automatic test_flash_win();
    hcount = 10'd300;
    vcount = 10'd300;
    win = 1'b1;
    vsync = 1'b1;  // coincident edge must not count
    tick(1);
    n_cmp++;
    if (flash_state !== 2'd1) begin
      n_err++; $display("FAIL flash_entry: got %0d want 1", flash_state);
    end
    tick(1);
    vsync = 1'b0;
    tick(2);
    n_cmp++;
    if (rgb !== 3'd7) begin
      n_err++; $display("FAIL flash_on_rgb: got rgb=%0d want 7", rgb);
    end
    repeat (7) vsync_pulse();
    n_cmp++;
    if (flash_state !== 2'd1) begin
      n_err++; $display("FAIL flash_7_edges: got %0d want 1", flash_state);
    end
    vsync_pulse();
    n_cmp++;
    if (flash_state !== 2'd2 || rgb !== 3'd0) begin
      n_err++; $display("FAIL flash_8_edges: got fs=%0d rgb=%0d want 2/0", flash_state, rgb);
    end
    show(0, 0);
    n_cmp++;
    if (rgb !== 3'd0) begin
      n_err++; $display("FAIL flash_off_border: got rgb=%0d want 0", rgb);
    end
    repeat (8) vsync_pulse();
    n_cmp++;
    if (flash_state !== 2'd1 || rgb !== 3'd7) begin
      n_err++; $display("FAIL flash_16_edges: got fs=%0d rgb=%0d want 1/7", flash_state, rgb);
    end
    show(700, 10);
    n_cmp++;
    if (rgb !== 3'd0) begin
      n_err++; $display("FAIL flash_offscreen: got rgb=%0d want 0", rgb);
    end
    win = 1'b0;
    tick(1);
    n_cmp++;
    if (flash_state !== 2'd0) begin
      n_err++; $display("FAIL flash_exit: got %0d want 0", flash_state);
    end
    $display("flash_win: done");
  endtask

  task automatic test_flash_lose();
    hcount = 10'd300;
    vcount = 10'd300;
    lose = 1'b1;
    tick(1);
    n_cmp++;
    if (flash_state !== 2'd1) begin
      n_err++; $display("FAIL lose_entry: got %0d want 1", flash_state);
    end
    tick(1);
    n_cmp++;
    if (rgb !== 3'd1) begin
      n_err++; $display("FAIL lose_rgb: got rgb=%0d want 1", rgb);
    end
    win = 1'b1;
    tick(2);
    n_cmp++;
    if (rgb !== 3'd7) begin
      n_err++; $display("FAIL win_over_lose: got rgb=%0d want 7", rgb);
    end
    win = 1'b0;
    lose = 1'b0;
    tick(1);
    n_cmp++;
    if (flash_state !== 2'd0) begin
      n_err++; $display("FAIL lose_exit: got %0d want 0", flash_state);
    end
    $display("flash_lose: done");
  endtask

  initial begin
    reset = 1'b1;
    hcount = '0; vcount = '0; vsync = 1'b0;
    ball_x = 10'd300; ball_y = 10'd200; paddle_x = 10'd320;
    block_status = '0; win = 1'b0; lose = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    test_reset();
    test_brick();
    test_colour_sub();
    test_ball_paddle();
    test_visible_border();
    test_flash_win();
    test_flash_lose();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
